// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates from an H/V sync + RGB stream,
// measures line/frame geometry and locks once consecutive frames match the configured size.
module vga_sync_decoder #(
  parameter int unsigned H_SIZE      = 1600,
  parameter int unsigned V_SIZE      = 900,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned MAP_H_WIDTH = $clog2(H_SIZE + 1),
  parameter int unsigned MAP_V_WIDTH = $clog2(V_SIZE + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_H_sync,
  input  logic                   i_V_sync,
  input  logic [23:0]            i_RGB,
  input  logic                   i_RGB_valid,
  output logic [23:0]            o_RGB,
  output logic                   o_pixel_valid,
  output logic [MAP_H_WIDTH-1:0] o_x,
  output logic [MAP_V_WIDTH-1:0] o_y,
  output logic [15:0]            o_line_period,
  output logic [15:0]            o_active_width,
  output logic [15:0]            o_active_lines,
  output logic                   o_frame_done,
  output logic                   o_locked,
  output logic                   o_line_error,
  output logic                   o_frame_error
);

  typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

  state_e                 state_q, state_d;
  logic                   hs_q, vs_q;
  logic [15:0]            period_q, period_d;
  logic [15:0]            width_q, width_d;
  logic [15:0]            line_cnt_q, line_cnt_d;
  logic                   line_bad_q, line_bad_d;
  logic [3:0]             good_cnt_q, good_cnt_d;
  logic [15:0]            line_period_q, line_period_d;
  logic [15:0]            active_width_q, active_width_d;
  logic [15:0]            active_lines_q, active_lines_d;
  logic [23:0]            rgb_q, rgb_d;
  logic                   pix_valid_q, pix_valid_d;
  logic [MAP_H_WIDTH-1:0] x_q, x_d;
  logic [MAP_V_WIDTH-1:0] y_q, y_d;
  logic                   frame_done_q, frame_done_d;
  logic                   locked_q, locked_d;
  logic                   line_error_q, line_error_d;
  logic                   frame_error_q, frame_error_d;

  logic        hs_fall, vs_fall, line_close, line_close_bad, frame_good;
  logic [15:0] width_base, line_cnt_close;
  logic        line_bad_close;
  logic [15:0] y_full;

  assign hs_fall        = hs_q & ~i_H_sync;
  assign vs_fall        = vs_q & ~i_V_sync;
  assign line_close     = hs_fall && (width_q != 16'd0);
  assign line_close_bad = line_close && (width_q != 16'(H_SIZE));
  // A line closing in the vs_fall cycle still belongs to the frame being judged.
  assign line_cnt_close = line_cnt_q + {15'd0, line_close};
  assign line_bad_close = line_bad_q | line_close_bad;
  assign frame_good     = (line_cnt_close == 16'(V_SIZE)) && !line_bad_close;
  assign width_base     = hs_fall ? 16'd0 : width_q;

  always_comb begin
    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    period_d       = (period_q == 16'hFFFF) ? period_q : period_q + 16'd1;
    line_period_d  = line_period_q;
    active_width_d = active_width_q;
    active_lines_d = active_lines_q;
    line_cnt_d     = line_cnt_close;
    line_bad_d     = line_bad_close;
    line_error_d   = line_close_bad;
    frame_done_d   = 1'b0;
    frame_error_d  = 1'b0;
    x_d            = x_q;
    y_d            = y_q;
    y_full         = 16'd0;

    if (hs_fall) begin
      line_period_d = period_q;
      period_d      = 16'd1;
    end
    if (line_close) active_width_d = width_q;

    // The valid seen on the hs_fall cycle is the first pixel of the new line.
    if (i_RGB_valid && (width_base != 16'hFFFF)) width_d = width_base + 16'd1;
    else                                          width_d = width_base;

    if (vs_fall) begin
      active_lines_d = line_cnt_close;
      line_cnt_d     = 16'd0;
      line_bad_d     = 1'b0;
      frame_done_d   = 1'b1;
      unique case (state_q)
        StSearch: begin
          state_d    = StCheck;
          good_cnt_d = 4'd0;
        end
        StCheck: begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 == 4'(LOCK_FRAMES)) state_d = StLocked;
          end else begin
            good_cnt_d    = 4'd0;
            frame_error_d = 1'b1;
          end
        end
        StLocked: begin
          if (!frame_good) begin
            state_d       = StCheck;
            good_cnt_d    = 4'd0;
            frame_error_d = 1'b1;
          end
        end
        default: state_d = StSearch;
      endcase
    end

    rgb_d       = i_RGB;
    pix_valid_d = i_RGB_valid && (state_q != StSearch);
    if (pix_valid_d) begin
      y_full = line_cnt_d + 16'd1;
      x_d    = width_d[MAP_H_WIDTH-1:0];
      y_d    = y_full[MAP_V_WIDTH-1:0];
    end

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= StSearch;
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      period_q       <= 16'd0;
      width_q        <= 16'd0;
      line_cnt_q     <= 16'd0;
      line_bad_q     <= 1'b0;
      good_cnt_q     <= 4'd0;
      line_period_q  <= 16'd0;
      active_width_q <= 16'd0;
      active_lines_q <= 16'd0;
      rgb_q          <= 24'd0;
      pix_valid_q    <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      frame_done_q   <= 1'b0;
      locked_q       <= 1'b0;
      line_error_q   <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      hs_q           <= i_H_sync;
      vs_q           <= i_V_sync;
      period_q       <= period_d;
      width_q        <= width_d;
      line_cnt_q     <= line_cnt_d;
      line_bad_q     <= line_bad_d;
      good_cnt_q     <= good_cnt_d;
      line_period_q  <= line_period_d;
      active_width_q <= active_width_d;
      active_lines_q <= active_lines_d;
      rgb_q          <= rgb_d;
      pix_valid_q    <= pix_valid_d;
      x_q            <= x_d;
      y_q            <= y_d;
      frame_done_q   <= frame_done_d;
      locked_q       <= locked_d;
      line_error_q   <= line_error_d;
      frame_error_q  <= frame_error_d;
    end
  end

  assign o_RGB          = rgb_q;
  assign o_pixel_valid  = pix_valid_q;
  assign o_x            = x_q;
  assign o_y            = y_q;
  assign o_line_period  = line_period_q;
  assign o_active_width = active_width_q;
  assign o_active_lines = active_lines_q;
  assign o_frame_done   = frame_done_q;
  assign o_locked       = locked_q;
  assign o_line_error   = line_error_q;
  assign o_frame_error  = frame_error_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a miniature 8x4 raster (14-cycle lines).
module tb_vga_sync_decoder;

  localparam int unsigned H        = 8;
  localparam int unsigned V        = 4;
  localparam int unsigned LOCK     = 2;
  localparam int unsigned HW       = 4;
  localparam int unsigned VW       = 3;
  localparam int          LINE_LEN = 14;
  localparam int          RST_PIX  = 3;

  logic          i_clk, i_rst, i_H_sync, i_V_sync, i_RGB_valid;
  logic [23:0]   i_RGB;
  logic [23:0]   o_RGB;
  logic          o_pixel_valid;
  logic [HW-1:0] o_x;
  logic [VW-1:0] o_y;
  logic [15:0]   o_line_period, o_active_width, o_active_lines;
  logic          o_frame_done, o_locked, o_line_error, o_frame_error;

  vga_sync_decoder #(
    .H_SIZE     (H),
    .V_SIZE     (V),
    .LOCK_FRAMES(LOCK),
    .MAP_H_WIDTH(HW),
    .MAP_V_WIDTH(VW)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_H_sync      (i_H_sync),
    .i_V_sync      (i_V_sync),
    .i_RGB         (i_RGB),
    .i_RGB_valid   (i_RGB_valid),
    .o_RGB         (o_RGB),
    .o_pixel_valid (o_pixel_valid),
    .o_x           (o_x),
    .o_y           (o_y),
    .o_line_period (o_line_period),
    .o_active_width(o_active_width),
    .o_active_lines(o_active_lines),
    .o_frame_done  (o_frame_done),
    .o_locked      (o_locked),
    .o_line_error  (o_line_error),
    .o_frame_error (o_frame_error)
  );

  typedef struct packed {
    logic [23:0]   rgb;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
  } pix_t;

  typedef struct {
    int lines;
    bit err;
    bit locked;
    int width;
    int period;  // negative: not checked
  } frm_t;

  pix_t pix_q[$];
  frm_t frm_q[$];
  int   lerr_q[$];

  int total = 0;
  int bad   = 0;
  bit searching;
  int rst_req  = 0;
  int rst_seen = 0;
  bit done_req = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge i_clk) begin
    pix_t pe;
    frm_t fe;
    int   we;
    if (o_pixel_valid) begin
      if (pix_q.size() == 0) chk("unexpected_pixel", 1, 0);
      else begin
        pe = pix_q.pop_front();
        chk("pixel_rgb_x_y", {o_RGB, o_x, o_y}, pe);
      end
    end
    if (o_line_error) begin
      if (lerr_q.size() == 0) chk("unexpected_line_error", 1, 0);
      else begin
        we = lerr_q.pop_front();
        chk("line_error_width", o_active_width, we);
      end
    end
    if (o_frame_done) begin
      if (frm_q.size() == 0) chk("unexpected_frame_done", 1, 0);
      else begin
        fe = frm_q.pop_front();
        chk("active_lines", o_active_lines, fe.lines);
        chk("frame_error", o_frame_error, fe.err);
        chk("locked", o_locked, fe.locked);
        chk("active_width", o_active_width, fe.width);
        if (fe.period >= 0) chk("line_period", o_line_period, fe.period);
      end
    end else if (o_frame_error) begin
      chk("frame_error_without_done", 1, 0);
    end
    if (rst_req != rst_seen) begin
      rst_seen = rst_req;
      chk("rst_rgb", o_RGB, 0);
      chk("rst_pixel_valid", o_pixel_valid, 0);
      chk("rst_x", o_x, 0);
      chk("rst_y", o_y, 0);
      chk("rst_line_period", o_line_period, 0);
      chk("rst_active_width", o_active_width, 0);
      chk("rst_active_lines", o_active_lines, 0);
      chk("rst_pulses", {o_frame_done, o_line_error, o_frame_error}, 0);
      chk("rst_locked", o_locked, 0);
    end
    if (done_req) begin
      chk("pix_queue_left", pix_q.size(), 0);
      chk("frame_queue_left", frm_q.size(), 0);
      chk("line_err_queue_left", lerr_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic step(input logic hs, input logic vs, input logic v, input logic [23:0] rgb);
    i_H_sync    = hs;
    i_V_sync    = vs;
    i_RGB_valid = v;
    i_RGB       = rgb;
    @(posedge i_clk);
    #1;
  endtask

  // Frame = 2 blank lines under V_sync, then nlines active lines. Its opening vs_fall
  // judges the previous frame against exp.
  task automatic send_frame(input int nlines, input int drop_line, input int rst_line,
                            input frm_t exp);
    logic        hs, vs;
    logic [23:0] rgb;
    int          pix, a;
    frm_q.push_back(exp);
    for (int ln = 0; ln < nlines + 2; ln++) begin
      vs = (ln < 2) ? 1'b0 : 1'b1;
      a  = ln - 2;
      for (int c = 0; c < LINE_LEN; c++) begin
        hs  = (c < 2) ? 1'b0 : 1'b1;
        pix = c - 3;
        rgb = {8'hA5, 8'(a), 8'(pix)};
        if (ln >= 2 && pix >= 0 && pix < int'(H)) begin
          if (a == rst_line && pix == RST_PIX) begin
            i_rst = 1'b1;
            step(hs, vs, 1'b1, rgb);
            i_rst     = 1'b0;
            searching = 1'b1;
            rst_req++;
            lerr_q.push_back(int'(H) - 1 - RST_PIX);
          end else if (a == drop_line && pix == int'(H) - 1) begin
            lerr_q.push_back(int'(H) - 1);
            step(hs, vs, 1'b0, 24'h0);
          end else begin
            if (!searching) pix_q.push_back({rgb, HW'(pix + 1), VW'(a + 1)});
            step(hs, vs, 1'b1, rgb);
          end
        end else begin
          step(hs, vs, 1'b0, 24'h0);
        end
        if (ln == 0 && c == 0) searching = 1'b0;
      end
    end
  endtask

  initial begin
    i_rst       = 1'b1;
    i_H_sync    = 1'b1;
    i_V_sync    = 1'b1;
    i_RGB_valid = 1'b0;
    i_RGB       = 24'h0;
    searching   = 1'b1;
    @(posedge i_clk);
    #1;
    step(1'b1, 1'b1, 1'b0, 24'h0);
    i_rst = 1'b0;
    rst_req++;
    repeat (3) step(1'b1, 1'b1, 1'b0, 24'h0);

    send_frame(4, -1, -1, '{0, 1'b0, 1'b0, 0, -1});  // search -> check, no error
    send_frame(4, -1, -1, '{4, 1'b0, 1'b0, 8, 14});  // good 1
    send_frame(4,  1, -1, '{4, 1'b0, 1'b1, 8, 14});  // good 2 -> lock; line 1 short
    send_frame(4, -1, -1, '{4, 1'b1, 1'b0, 8, 14});  // bad -> unlock
    send_frame(3, -1, -1, '{4, 1'b0, 1'b0, 8, 14});  // good 1; only 3 lines
    send_frame(4, -1, -1, '{3, 1'b1, 1'b0, 8, 14});  // short frame -> error
    send_frame(4, -1, -1, '{4, 1'b0, 1'b0, 8, 14});  // good 1
    send_frame(4, -1, -1, '{4, 1'b0, 1'b1, 8, 14});  // good 2 -> lock
    send_frame(4, -1,  1, '{4, 1'b0, 1'b1, 8, 14});  // stay locked; reset mid-line 1
    send_frame(4, -1, -1, '{3, 1'b0, 1'b0, 8, 14});  // partial frame discarded
    send_frame(4, -1, -1, '{4, 1'b0, 1'b0, 8, 14});  // good 1
    send_frame(4,  3, -1, '{4, 1'b0, 1'b1, 8, 14});  // lock; last line short
    send_frame(0, -1, -1, '{4, 1'b1, 1'b0, 7, 14});  // coincident close makes frame bad
    repeat (5) step(1'b1, 1'b1, 1'b0, 24'h0);
    done_req = 1'b1;
    repeat (20) @(posedge i_clk);
    $display("FAIL end_of_test: monitor did not finish (got 0 expected 1)");
    $fatal(1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached (got timeout expected finish)");
    $fatal(1);
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator: samples an incoming H_sync/V_sync/RGB/RGB_valid stream, recovers 1-based pixel coordinates, measures line and frame geometry, and declares lock once consecutive frames match the configured resolution. Used for loopback verification of the display path and as the capture front end feeding frame-buffer writes.

## Interface
- H_SIZE, 1600, expected valid pixels per active line
- V_SIZE, 900, expected active lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)
- i_clk  in  1  pixel clock
- i_rst  in  1  reset; one clock, synchronous, active-high
- i_H_sync  in  1  horizontal sync, active low
- i_V_sync  in  1  vertical sync, active low
- i_RGB  in  24  pixel data
- i_RGB_valid  in  1  pixel data qualifier
- o_RGB  out  24  registered pixel data
- o_pixel_valid  out  1  registered valid, gated by state ≠ S_SEARCH
- o_x  out  sram_pkg::MAP_H_WIDTH  column of o_RGB, 1-based
- o_y  out  sram_pkg::MAP_V_WIDTH  row of o_RGB, 1-based
- o_line_period  out  16  cycles between last two H_sync falling edges
- o_active_width  out  16  valid count of last completed line
- o_active_lines  out  16  active lines in last completed frame
- o_frame_done  out  1  one-cycle pulse per V_sync falling edge
- o_locked  out  1  high in S_LOCKED
- o_line_error  out  1  one-cycle pulse, nonzero line width ≠ H_SIZE
- o_frame_error  out  1  one-cycle pulse, bad frame evaluated in S_CHECK/S_LOCKED

## Operation
- Edge detect: previous-sample registers hs_q, vs_q (reset 1); hs_fall = hs_q & ~i_H_sync; same for vs_fall.
- Period counter: increments every cycle, saturates at 65535; on hs_fall, copy to o_line_period, restart at 1.
- Line width counter: increments per i_RGB_valid (saturating 16 bit). On hs_fall: if width > 0, line closes: o_active_width ← width, line_cnt++, line_bad set if width ≠ H_SIZE, o_line_error pulses; width restarts at 0. Zero-width lines (blanking) ignored.
- Valid in hs_fall cycle belongs to the new line (width becomes 1).
- Coordinates: o_x = width after counting current pixel; o_y = line_cnt + 1.
- On vs_fall: frame evaluated; good = (line_cnt == V_SIZE) & ~line_bad; o_active_lines ← line_cnt; line_cnt, line_bad cleared; o_frame_done pulses.
- If hs_fall and vs_fall coincide: line close first, then frame evaluation includes that line.
- FSM:
  - S_SEARCH: on vs_fall → S_CHECK, good_cnt=0, no error pulse (partial frame).
  - S_CHECK: on vs_fall: good → good_cnt++, reaching LOCK_FRAMES → S_LOCKED; bad → good_cnt=0, o_frame_error.
  - S_LOCKED: on vs_fall: bad → S_CHECK, good_cnt=0, o_frame_error; good → stay.
- Reset mid-frame: all counters, measurements, FSM return to reset values; next partial frame discarded via S_SEARCH.

## Timing
- Reset values: o_RGB 0, o_pixel_valid 0, o_x 0, o_y 0, o_line_period 0, o_active_width 0, o_active_lines 0, all pulses 0, o_locked 0, state S_SEARCH.
- o_RGB/o_pixel_valid/o_x/o_y: one cycle after i_RGB/i_RGB_valid.
- Measurements, pulses, o_locked: register update in cycle after the triggering edge sample (hs_fall/vs_fall computed on the input sample, outputs valid next clock).
- o_locked rises one cycle after the LOCK_FRAMES-th good vs_fall after entering S_CHECK.
- o_x/o_y hold last values while o_pixel_valid is 0.

## Test plan
- Generator at 640x480@60, H_SIZE=640, V_SIZE=480 -> o_line_period 800, o_active_width 640, o_active_lines 480; o_locked rises at 3rd vs_fall after reset (1 search + 2 good).
- Default 1600x900 stream -> o_line_period 1800; first valid of frame gives o_x=1,o_y=1; last gives o_x=1600,o_y=900.
- Drop one valid pixel in line 10 while locked -> o_line_error pulse at that line's hs_fall, o_active_width 1599; o_frame_error and o_locked=0 at next vs_fall; relock after 2 clean frames.
- Frame with 899 active lines -> o_active_lines 899, o_frame_error pulse, good_cnt cleared.
- Assert i_rst for one clock mid-line while locked -> all outputs reset next cycle; o_pixel_valid stays 0 until first vs_fall.
- Force hs_fall and vs_fall in same cycle ending a 900th line -> frame judged good, o_active_lines 900.
